// File: rtl/regfile_access_sched_pkg.sv
// Shared constants for the register-file access scheduler.
//   - register index map (left group 0..1, right group 2..13)
//   - select width, port count, FSM state encoding
//   - is_right(): true when an index lives in the right (data-side) group
package regfile_access_sched_pkg;

  localparam int SEL_W     = 14;
  localparam int IDX_W     = 4;
  localparam int NUM_PORTS = 2;   // 0 = port A (left bus), 1 = port B (right bus)

  localparam logic [IDX_W-1:0] IDX_PC  = 4'd0;
  localparam logic [IDX_W-1:0] IDX_IR  = 4'd1;
  localparam logic [IDX_W-1:0] IDX_WZ  = 4'd2;
  localparam logic [IDX_W-1:0] IDX_SP  = 4'd3;
  localparam logic [IDX_W-1:0] IDX_IY  = 4'd4;
  localparam logic [IDX_W-1:0] IDX_IX  = 4'd5;
  localparam logic [IDX_W-1:0] IDX_HL1 = 4'd6;
  localparam logic [IDX_W-1:0] IDX_HL0 = 4'd7;
  localparam logic [IDX_W-1:0] IDX_DE1 = 4'd8;
  localparam logic [IDX_W-1:0] IDX_DE0 = 4'd9;
  localparam logic [IDX_W-1:0] IDX_BC1 = 4'd10;
  localparam logic [IDX_W-1:0] IDX_BC0 = 4'd11;
  localparam logic [IDX_W-1:0] IDX_AF1 = 4'd12;
  localparam logic [IDX_W-1:0] IDX_AF0 = 4'd13;

  // First index of the right group.
  localparam logic [IDX_W-1:0] GRP_BOUND = 4'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  function automatic logic is_right(input logic [IDX_W-1:0] idx);
    return (idx >= GRP_BOUND) && (idx <= IDX_AF0);
  endfunction

endpackage

// File: rtl/regfile_access_sched_decode.sv
// regsched_decode: maps a register index plus the swap flags to a one-hot
// slice select.
//   idx_i      register index (14/15 are illegal)
//   swap_af_i  exchange af1/af0
//   swap_x_i   exchange hl1/hl0, de1/de0, bc1/bc0
//   sel_o      one-hot select, zero for an illegal index
//   legal_o    index is 0..13
module regsched_decode
  import regfile_access_sched_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             swap_af_i,
  input  logic             swap_x_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             legal_o
);

  logic [IDX_W-1:0] phys;

  always_comb begin
    phys = idx_i;
    // Paired registers sit on adjacent even/odd indices, so a swap is a bit-0 flip.
    if (swap_af_i && idx_i >= IDX_AF1 && idx_i <= IDX_AF0) phys = idx_i ^ 4'd1;
    if (swap_x_i  && idx_i >= IDX_HL1 && idx_i <= IDX_BC0) phys = idx_i ^ 4'd1;
    legal_o = (idx_i <= IDX_AF0);
    sel_o   = legal_o ? ({{(SEL_W-1){1'b0}}, 1'b1} << phys) : '0;
  end

endmodule

// File: rtl/regfile_access_sched.sv
// regfile_access_sched: arbitrates two requesters onto a 14-entry register
// slice array with a shared left/right bus join.
//   eclk, erst            clock, synchronous active-high reset
//   a_valid/a_we/a_idx    port A request (left-bus owner)
//   b_valid/b_we/b_idx    port B request (right-bus owner)
//   a_ready/b_ready       access-complete pulses
//   a_rvalid/b_rvalid     read-data-valid pulses (one cycle after read ready)
//   ex_af, exx            swap-flag toggle pulses
//   sel                   one-hot slice select
//   pc_wr/reg_wr/r_p      left write, right write, bus join
//   err                   illegal-index pulse
// Build option: define REGSCHED_SWAP_EN to enable the af / bc-de-hl swap flags.
module regfile_access_sched
  import regfile_access_sched_pkg::*;
#(
  parameter int WR_HOLD = 1   // extra write cycles after DRIVE, 0..3
) (
  input  logic             eclk,
  input  logic             erst,
  input  logic             a_valid,
  input  logic             a_we,
  input  logic [IDX_W-1:0] a_idx,
  input  logic             b_valid,
  input  logic             b_we,
  input  logic [IDX_W-1:0] b_idx,
  output logic             a_ready,
  output logic             b_ready,
  output logic             a_rvalid,
  output logic             b_rvalid,
  input  logic             ex_af,
  input  logic             exx,
  output logic [SEL_W-1:0] sel,
  output logic             pc_wr,
  output logic             reg_wr,
  output logic             r_p,
  output logic             err
);

  logic swap_af_q, swap_x_q;

`ifdef REGSCHED_SWAP_EN
  always_ff @(posedge eclk) begin
    if (erst) begin
      swap_af_q <= 1'b0;
      swap_x_q  <= 1'b0;
    end else begin
      if (ex_af) swap_af_q <= ~swap_af_q;
      if (exx)   swap_x_q  <= ~swap_x_q;
    end
  end
`else
  assign swap_af_q = 1'b0;
  assign swap_x_q  = 1'b0;
  logic unused_swap;
  assign unused_swap = ex_af ^ exx;
`endif

  logic [NUM_PORTS-1:0]            vld, we, jn, gnt, dlegal;
  logic [NUM_PORTS-1:0][IDX_W-1:0] idx;
  logic [NUM_PORTS-1:0][SEL_W-1:0] dsel;
  logic                            dual, last;

  assign vld = {b_valid, a_valid};
  assign we  = {b_we, a_we};
  assign idx = {b_idx, a_idx};
  // A crosses the join to reach the right group, B to reach the left group.
  assign jn  = {(b_idx < GRP_BOUND), is_right(a_idx)};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dec
    regsched_decode u_dec (
      .idx_i     (idx[i]),
      .swap_af_i (swap_af_q),
      .swap_x_i  (swap_x_q),
      .sel_o     (dsel[i]),
      .legal_o   (dlegal[i])
    );
  end

  // rr_q = 0 gives A priority on a conflict, 1 gives B priority.
  logic                            rr_q, rr_d, rp_q, rp_d;
  logic [1:0]                      st_q, st_d, cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]            act_q, act_d, long_q, long_d, ill_q, ill_d;
  logic [NUM_PORTS-1:0]            we_q, we_d, rv_q, rv_d;
  logic [NUM_PORTS-1:0][SEL_W-1:0] sel_q, sel_d;

  assign dual   = (&vld) && !(|jn) && (&dlegal);
  assign gnt[0] = vld[0] && (dual || !vld[1] || !rr_q);
  assign gnt[1] = vld[1] && (dual || !vld[0] ||  rr_q);
  assign last   = (st_q == ST_DRIVE && WR_HOLD == 0) || (st_q == ST_HOLD && cnt_q == 2'd0);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    long_d = long_q;
    ill_d  = ill_q;
    we_d   = we_q;
    sel_d  = sel_q;
    rp_d   = rp_q;
    rr_d   = rr_q;
    rv_d   = '0;
    case (st_q)
      ST_IDLE: if (|gnt) begin
        st_d   = ST_DRIVE;
        act_d  = gnt;
        we_d   = we;
        sel_d  = dsel;
        ill_d  = ~dlegal;
        long_d = gnt & we & dlegal;   // only legal writes occupy HOLD
        rp_d   = !dual && (gnt[0] ? jn[0] : jn[1]);
        if (!dual) rr_d = gnt[0];     // hand priority to the port not served
      end
      ST_DRIVE: begin
        rv_d = act_q & ~we_q & ~ill_q;
        if (WR_HOLD != 0 && |(act_q & long_q)) begin
          st_d  = ST_HOLD;
          cnt_d = 2'(WR_HOLD - 1);
          act_d = act_q & long_q;     // a read paired with a write drops out here
        end else begin
          st_d  = ST_IDLE;
          act_d = '0;
          rp_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 2'd0) begin
          st_d  = ST_IDLE;
          act_d = '0;
          rp_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        act_d = '0;
        rp_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge eclk) begin
    if (erst) begin
      st_q   <= ST_IDLE;
      cnt_q  <= 2'd0;
      act_q  <= '0;
      long_q <= '0;
      ill_q  <= '0;
      we_q   <= '0;
      sel_q  <= '0;
      rp_q   <= 1'b0;
      rr_q   <= 1'b0;
      rv_q   <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      long_q <= long_d;
      ill_q  <= ill_d;
      we_q   <= we_d;
      sel_q  <= sel_d;
      rp_q   <= rp_d;
      rr_q   <= rr_d;
      rv_q   <= rv_d;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (act_q[i]) sel |= sel_q[i];
  end

  assign pc_wr  = act_q[0] & long_q[0];
  assign reg_wr = act_q[1] & long_q[1];
  assign r_p    = rp_q;

  // Handshake pulses are masked by erst so an access cut by reset never completes.
  assign a_ready  = act_q[0] & (~long_q[0] | last) & ~erst;
  assign b_ready  = act_q[1] & (~long_q[1] | last) & ~erst;
  assign a_rvalid = rv_q[0] & ~erst;
  assign b_rvalid = rv_q[1] & ~erst;
  assign err      = |(act_q & ill_q) & ~erst;

endmodule

// File: tb/tb_regfile_access_sched.sv
module tb_regfile_access_sched;
  localparam int WR_HOLD = 1;

  logic        eclk = 1'b0, erst = 1'b1;
  logic        a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic        ex_af = 1'b0, exx = 1'b0;
  logic [3:0]  a_idx = 4'd0, b_idx = 4'd0;
  logic        a_ready, b_ready, a_rvalid, b_rvalid, pc_wr, reg_wr, r_p, err;
  logic [13:0] sel;

  regfile_access_sched #(.WR_HOLD(WR_HOLD)) dut (
    .eclk(eclk), .erst(erst),
    .a_valid(a_valid), .a_we(a_we), .a_idx(a_idx),
    .b_valid(b_valid), .b_we(b_we), .b_idx(b_idx),
    .a_ready(a_ready), .b_ready(b_ready), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .ex_af(ex_af), .exx(exx), .sel(sel),
    .pc_wr(pc_wr), .reg_wr(reg_wr), .r_p(r_p), .err(err)
  );

  always #5 eclk = ~eclk;

  typedef struct {
    int          cyc;
    logic [13:0] sel;
    logic        pc_wr, reg_wr, r_p, err;
  } rsp_t;

  rsp_t qa[$], qb[$];
  int   qra[$], qrb[$];
  int   cyc = 0, free_cyc = 0;
  bit   rr_b = 1'b0, saf = 1'b0, sx = 1'b0;
  int   checks = 0, errors = 0;
  bit   a_done = 1'b0, b_done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Physical register selected by an index under the current swap state; -1 if illegal.
  function automatic int phys(input int i, input bit f_af, input bit f_x);
    if (i > 13) return -1;
    if (f_af && i >= 12) return i ^ 1;
    if (f_x && i >= 6 && i <= 11) return i ^ 1;
    return i;
  endfunction

  function automatic logic [13:0] mask(input int p);
    return (p < 0) ? 14'd0 : (14'd1 << p);
  endfunction

  // Transaction-level reference: decide who is served this cycle and when each
  // visible event must appear.
  task automatic model_grant();
    int   pa, pb, la, lb, n, lmax;
    bit   ja, jb, both, ga, gb, rp, wa, wb;
    logic [13:0] ma, mb;
    rsp_t r;
    pa   = phys(int'(a_idx), saf, sx);
    pb   = phys(int'(b_idx), saf, sx);
    ja   = (a_idx >= 2 && a_idx <= 13);
    jb   = (b_idx <= 1);
    both = a_valid && b_valid && !ja && !jb && pa >= 0 && pb >= 0;
    ga   = a_valid && (both || !b_valid || !rr_b);
    gb   = b_valid && (both || !a_valid || rr_b);
    if (!both) rr_b = ga;
    rp   = !both && (ga ? ja : jb);
    wa   = ga && a_we && pa >= 0;
    wb   = gb && b_we && pb >= 0;
    la   = wa ? 1 + WR_HOLD : 1;
    lb   = wb ? 1 + WR_HOLD : 1;
    ma   = ga ? mask(pa) : 14'd0;
    mb   = gb ? mask(pb) : 14'd0;
    n    = cyc;
    lmax = 0;
    if (ga) begin
      r.cyc = n + la; r.sel = ma | ((lb >= la) ? mb : 14'd0);
      r.pc_wr = wa; r.reg_wr = wb && (lb >= la); r.r_p = rp; r.err = (pa < 0);
      qa.push_back(r);
      if (!a_we && pa >= 0) qra.push_back(n + 2);
      lmax = la;
    end
    if (gb) begin
      r.cyc = n + lb; r.sel = mb | ((la >= lb) ? ma : 14'd0);
      r.pc_wr = wa && (la >= lb); r.reg_wr = wb; r.r_p = rp; r.err = (pb < 0);
      qb.push_back(r);
      if (!b_we && pb >= 0) qrb.push_back(n + 2);
      if (lb > lmax) lmax = lb;
    end
    free_cyc = n + 1 + lmax;
  endtask

  // Reference model: sees each cycle's inputs at the edge that ends it.
  initial forever begin
    @(posedge eclk);
    if (erst) begin
      while (qa.size() > 0 && qa[qa.size()-1].cyc >= cyc) qa.delete(qa.size()-1);
      while (qb.size() > 0 && qb[qb.size()-1].cyc >= cyc) qb.delete(qb.size()-1);
      while (qra.size() > 0 && qra[qra.size()-1] >= cyc) qra.delete(qra.size()-1);
      while (qrb.size() > 0 && qrb[qrb.size()-1] >= cyc) qrb.delete(qrb.size()-1);
      free_cyc = cyc + 1;
      rr_b = 1'b0; saf = 1'b0; sx = 1'b0;
    end else begin
      if (cyc >= free_cyc && (a_valid || b_valid)) model_grant();
`ifdef REGSCHED_SWAP_EN
      if (ex_af) saf = !saf;
      if (exx)   sx  = !sx;
`endif
    end
    cyc++;
  end

  // Monitor: pops expectations whenever the DUT presents a handshake.
  initial forever begin
    rsp_t r;
    @(negedge eclk);
    while (qa.size() > 0 && qa[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL a_ready_missing: absent, required at cycle %0d (now %0d)", qa[0].cyc, cyc);
      void'(qa.pop_front());
    end
    while (qb.size() > 0 && qb[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL b_ready_missing: absent, required at cycle %0d (now %0d)", qb[0].cyc, cyc);
      void'(qb.pop_front());
    end
    while (qra.size() > 0 && qra[0] < cyc) begin
      checks++; errors++;
      $display("FAIL a_rvalid_missing: absent, required at cycle %0d", qra[0]);
      void'(qra.pop_front());
    end
    while (qrb.size() > 0 && qrb[0] < cyc) begin
      checks++; errors++;
      $display("FAIL b_rvalid_missing: absent, required at cycle %0d", qrb[0]);
      void'(qrb.pop_front());
    end
    if (a_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++; $display("FAIL a_ready_unexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        r = qa.pop_front();
        chk("a_ready_cycle", cyc, r.cyc);
        chk("a_sel", int'(sel), int'(r.sel));
        chk("a_pc_wr", int'(pc_wr), int'(r.pc_wr));
        chk("a_reg_wr", int'(reg_wr), int'(r.reg_wr));
        chk("a_r_p", int'(r_p), int'(r.r_p));
        chk("a_err", int'(err), int'(r.err));
      end
    end
    if (b_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++; $display("FAIL b_ready_unexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        r = qb.pop_front();
        chk("b_ready_cycle", cyc, r.cyc);
        chk("b_sel", int'(sel), int'(r.sel));
        chk("b_pc_wr", int'(pc_wr), int'(r.pc_wr));
        chk("b_reg_wr", int'(reg_wr), int'(r.reg_wr));
        chk("b_r_p", int'(r_p), int'(r.r_p));
        chk("b_err", int'(err), int'(r.err));
      end
    end
    if (a_rvalid) begin
      if (qra.size() == 0) begin
        checks++; errors++; $display("FAIL a_rvalid_unexpected: pulse at cycle %0d", cyc);
      end else chk("a_rvalid_cycle", cyc, qra.pop_front());
    end
    if (b_rvalid) begin
      if (qrb.size() == 0) begin
        checks++; errors++; $display("FAIL b_rvalid_unexpected: pulse at cycle %0d", cyc);
      end else chk("b_rvalid_cycle", cyc, qrb.pop_front());
    end
    if (err && !a_ready && !b_ready) begin
      checks++; errors++; $display("FAIL err_alone: err=1 without ready at cycle %0d", cyc);
    end
  end

  task automatic step();
    @(posedge eclk); #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; ex_af = 1'b0; exx = 1'b0;
    erst = 1'b1; step(); step();
    erst = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    erst = 1'b0;
    @(negedge eclk);
    chk("rst_sel", int'(sel), 0);
    chk("rst_wr", int'({pc_wr, reg_wr, r_p}), 0);
    chk("rst_hs", int'({a_ready, b_ready, a_rvalid, b_rvalid, err}), 0);

    // Dual read: A idx 0 with B idx 3.
    step(); do_reset();
    a_valid = 1; a_we = 0; a_idx = 4'd0; b_valid = 1; b_we = 0; b_idx = 4'd3;
    step(); @(negedge eclk);
    chk("dual_sel", int'(sel), 'h0009);
    chk("dual_r_p", int'(r_p), 0);
    chk("dual_ready", int'({a_ready, b_ready}), 3);
    step(); a_valid = 0; b_valid = 0; @(negedge eclk);
    chk("dual_rvalid", int'({a_rvalid, b_rvalid}), 3);

    // Round-robin: both write idx 7.
    step(); do_reset();
    a_valid = 1; a_we = 1; a_idx = 4'd7; b_valid = 1; b_we = 1; b_idx = 4'd7;
    step(); @(negedge eclk);
    chk("rr_a_sel0", int'(sel), 'h0080);
    chk("rr_a_ctl0", int'({pc_wr, reg_wr, r_p, a_ready}), 'b1010);
    step(); @(negedge eclk);
    chk("rr_a_sel1", int'(sel), 'h0080);
    chk("rr_a_ctl1", int'({pc_wr, reg_wr, r_p, a_ready}), 'b1011);
    step(); a_valid = 0; @(negedge eclk);
    chk("rr_gap_sel", int'(sel), 0);
    step(); @(negedge eclk);
    chk("rr_b_sel0", int'(sel), 'h0080);
    chk("rr_b_ctl0", int'({pc_wr, reg_wr, r_p, b_ready}), 'b0100);
    step(); @(negedge eclk);
    chk("rr_b_ctl1", int'({pc_wr, reg_wr, r_p, b_ready}), 'b0101);
    step(); b_valid = 0;

    // Illegal index on B.
    do_reset();
    b_valid = 1; b_we = 0; b_idx = 4'd15;
    step(); @(negedge eclk);
    chk("ill_sel", int'(sel), 0);
    chk("ill_err_ready", int'({err, b_ready}), 3);
    step(); b_valid = 0; @(negedge eclk);
    chk("ill_no_rvalid", int'(b_rvalid), 0);
    step();

`ifdef REGSCHED_SWAP_EN
    do_reset();
    ex_af = 1; step();
    ex_af = 0; a_valid = 1; a_we = 0; a_idx = 4'd13;
    step(); @(negedge eclk);
    chk("swap1_sel", int'(sel), 'h1000);
    chk("swap1_r_p", int'(r_p), 1);
    step(); a_valid = 0; ex_af = 1;
    step(); ex_af = 0; a_valid = 1; a_idx = 4'd13;
    step(); @(negedge eclk);
    chk("swap2_sel", int'(sel), 'h2000);
    step(); a_valid = 0;
`endif

    // Reset during HOLD of an A write.
    do_reset();
    a_valid = 1; a_we = 1; a_idx = 4'd2;
    step(); step();
    erst = 1; a_valid = 0; @(negedge eclk);
    chk("rstw_no_ready", int'(a_ready), 0);
    step(); erst = 0;
    a_valid = 1; a_we = 1; a_idx = 4'd7; b_valid = 1; b_we = 1; b_idx = 4'd7;
    @(negedge eclk);
    chk("rstw_sel", int'(sel), 0);
    chk("rstw_ctl", int'({pc_wr, reg_wr, r_p, a_ready, b_ready}), 0);
    step(); @(negedge eclk);
    chk("rstw_ptr_a", int'({pc_wr, reg_wr}), 'b10);
    step(); do_reset();

    // Randomised traffic with occasional reset and swap pulses.
    a_done = 0; b_done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (a_done) begin a_valid = 0; a_done = 0; end
      else if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1; a_we = 1'($urandom_range(0, 1)); a_idx = 4'($urandom_range(0, 15));
      end
      if (b_done) begin b_valid = 0; b_done = 0; end
      else if (!b_valid && $urandom_range(0, 2) != 0) begin
        b_valid = 1; b_we = 1'($urandom_range(0, 1)); b_idx = 4'($urandom_range(0, 15));
      end
      ex_af = ($urandom_range(0, 7) == 0);
      exx   = ($urandom_range(0, 7) == 0);
      erst  = ($urandom_range(0, 199) == 0);
      @(negedge eclk);
      if (a_ready) a_done = 1;
      if (b_ready) b_done = 1;
      step();
    end
    a_valid = 0; b_valid = 0; ex_af = 0; exx = 0; erst = 0;
    repeat (10) step();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qra_drained", qra.size(), 0);
    chk("qrb_drained", qrb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
